mc_control_ext: RTL

- Parametrised successor to the 4-state R-format-only multicycle control FSM.
- Full multicycle MIPS-subset controller:
  - decodes OPCODE in DECODE and runs per-class sequences for R-type, LW, SW, BEQ, J and ADDI;
  - stalls on a memory-ready handshake;
  - counts retired instructions.
- Sits between the instruction register and the datapath muxes, register file, ALU and memory port.

---
 rtl/mc_control_ext_if.sv | 50 +++++
 rtl/mc_control_ext.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mc_control_ext_if.sv
// rtl/mc_control_ext_if.sv - control bus between the multicycle controller and the datapath
// Optional port ILLEGAL exists only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
interface mc_control_ext_if #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2,
  parameter int CNT_W  = 16
);
  logic [OPW-1:0]    OPCODE;
  logic              MEM_RDY;
  logic              PC_LD;
  logic              PC_LD_COND;
  logic              SEL_DIR;
  logic              MEM_RD;
  logic              MEM_WD;
  logic              IR_W;
  logic              SEL_DEST;
  logic              SEL_DAT;
  logic              REG_RD;
  logic              REG_WR;
  logic              SEL_OPERA;
  logic [1:0]        SEL_OPERAB;
  logic [1:0]        SEL_PC;
  logic [ALUOPW-1:0] ALU_OP;
  logic              RETIRE;
  logic [CNT_W-1:0]  INSTR_CNT;
  logic [3:0]        STATE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic              ILLEGAL;
`endif

  modport master (
    input  OPCODE, MEM_RDY,
    output PC_LD, PC_LD_COND, SEL_DIR, MEM_RD, MEM_WD, IR_W, SEL_DEST, SEL_DAT,
           REG_RD, REG_WR, SEL_OPERA, SEL_OPERAB, SEL_PC, ALU_OP, RETIRE,
           INSTR_CNT, STATE
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , output ILLEGAL
`endif
  );

  modport slave (
    output OPCODE, MEM_RDY,
    input  PC_LD, PC_LD_COND, SEL_DIR, MEM_RD, MEM_WD, IR_W, SEL_DEST, SEL_DAT,
           REG_RD, REG_WR, SEL_OPERA, SEL_OPERAB, SEL_PC, ALU_OP, RETIRE,
           INSTR_CNT, STATE
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    , input ILLEGAL
`endif
  );
endinterface

// File: rtl/mc_control_ext.sv
// rtl/mc_control_ext.sv - multicycle MIPS-subset control FSM with retire counter
// Optional feature macro: MC_CTRL_ILLEGAL_TRAP_EN (illegal opcode traps instead of acting as NOP).
module mc_control_ext #(
  parameter int OPW    = 6,
  parameter int ALUOPW = 2,
  parameter int CNT_W  = 16,
  parameter logic [OPW-1:0] OP_R    = OPW'('h00),
  parameter logic [OPW-1:0] OP_LW   = OPW'('h23),
  parameter logic [OPW-1:0] OP_SW   = OPW'('h2B),
  parameter logic [OPW-1:0] OP_BEQ  = OPW'('h04),
  parameter logic [OPW-1:0] OP_J    = OPW'('h02),
  parameter logic [OPW-1:0] OP_ADDI = OPW'('h08)
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_ext_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [ALUOPW-1:0] ALU_ADD   = ALUOPW'(0);
  localparam logic [ALUOPW-1:0] ALU_SUB   = ALUOPW'(1);
  localparam logic [ALUOPW-1:0] ALU_FUNCT = ALUOPW'(2);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             retire;
  logic             legal;

  assign legal = (bus.OPCODE == OP_R)  || (bus.OPCODE == OP_LW)  ||
                 (bus.OPCODE == OP_SW) || (bus.OPCODE == OP_BEQ) ||
                 (bus.OPCODE == OP_J)  || (bus.OPCODE == OP_ADDI);

  // State sequencing and saturating retire counter; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      if (retire && (cnt != {CNT_W{1'b1}})) cnt <= cnt + 1'b1;
      case (state)
        S_FETCH:     if (bus.MEM_RDY) state <= S_DECODE;
        S_DECODE: begin
          if (bus.OPCODE == OP_R)                               state <= S_EXEC_R;
          else if (bus.OPCODE == OP_LW || bus.OPCODE == OP_SW)  state <= S_MEM_ADDR;
          else if (bus.OPCODE == OP_BEQ)                        state <= S_BRANCH;
          else if (bus.OPCODE == OP_J)                          state <= S_JUMP;
          else if (bus.OPCODE == OP_ADDI)                       state <= S_ADDI_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          else                                                  state <= S_TRAP;
`else
          else                                                  state <= S_FETCH;
`endif
        end
        S_MEM_ADDR:  state <= (bus.OPCODE == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (bus.MEM_RDY) state <= S_MEM_WB;
        S_MEM_WRITE: if (bus.MEM_RDY) state <= S_FETCH;
        S_EXEC_R:    state <= S_R_WB;
        S_ADDI_EXEC: state <= S_ADDI_WB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP:      state <= S_TRAP;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the state register; held at zero while reset is asserted
  always_comb begin
    bus.PC_LD      = 1'b0;
    bus.PC_LD_COND = 1'b0;
    bus.SEL_DIR    = 1'b0;
    bus.MEM_RD     = 1'b0;
    bus.MEM_WD     = 1'b0;
    bus.IR_W       = 1'b0;
    bus.SEL_DEST   = 1'b0;
    bus.SEL_DAT    = 1'b0;
    bus.REG_RD     = 1'b0;
    bus.REG_WR     = 1'b0;
    bus.SEL_OPERA  = 1'b0;
    bus.SEL_OPERAB = 2'd0;
    bus.SEL_PC     = 2'd0;
    bus.ALU_OP     = ALU_ADD;
    retire         = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          bus.MEM_RD     = 1'b1;
          bus.SEL_OPERAB = 2'd1;
          bus.IR_W       = bus.MEM_RDY;
          bus.PC_LD      = bus.MEM_RDY;
        end
        S_DECODE: begin
          bus.REG_RD     = 1'b1;
          bus.SEL_OPERAB = 2'd3;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
          retire         = !legal;
`endif
        end
        S_MEM_ADDR: begin
          bus.SEL_OPERA  = 1'b1;
          bus.SEL_OPERAB = 2'd2;
        end
        S_MEM_READ: begin
          bus.MEM_RD  = 1'b1;
          bus.SEL_DIR = 1'b1;
        end
        S_MEM_WB: begin
          bus.REG_WR = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.MEM_WD = 1'b1;
          bus.SEL_DIR = 1'b1;
          retire     = bus.MEM_RDY;
        end
        S_EXEC_R: begin
          bus.SEL_OPERA = 1'b1;
          bus.ALU_OP    = ALU_FUNCT;
        end
        S_R_WB: begin
          bus.REG_WR   = 1'b1;
          bus.SEL_DEST = 1'b1;
          bus.SEL_DAT  = 1'b1;
          retire       = 1'b1;
        end
        S_BRANCH: begin
          bus.SEL_OPERA  = 1'b1;
          bus.ALU_OP     = ALU_SUB;
          bus.SEL_PC     = 2'd1;
          bus.PC_LD_COND = 1'b1;
          retire         = 1'b1;
        end
        S_JUMP: begin
          bus.SEL_PC = 2'd2;
          bus.PC_LD  = 1'b1;
          retire     = 1'b1;
        end
        S_ADDI_EXEC: begin
          bus.SEL_OPERA  = 1'b1;
          bus.SEL_OPERAB = 2'd2;
        end
        S_ADDI_WB: begin
          bus.REG_WR  = 1'b1;
          bus.SEL_DAT = 1'b1;
          retire      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.RETIRE    = retire;
  assign bus.INSTR_CNT = cnt;
  assign bus.STATE     = state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign bus.ILLEGAL   = reset && (state == S_TRAP);
`endif

endmodule
